trigger_sequencer: RTL

TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

---
 rtl/trig_pkg.sv | 26 ++
 rtl/bin_window_hit.sv | 38 +++
 rtl/trigger_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/trig_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trig_pkg
// Purpose  : Shared types and widths for the FFT-bin trigger sequencer.
// Revision : 1.0
// ============================================================================
package trig_pkg;

    localparam int c_bin_w           = 8;
    localparam int c_mag_w           = 16;
    localparam int c_fft_len_default = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    // Two's-complement absolute value; 0x8000 maps to 0x8000 as an unsigned magnitude.
    function automatic logic [c_mag_w-1:0] abs_mag(input logic [c_mag_w-1:0] v);
        return v[c_mag_w-1] ? c_mag_w'(~v + 1'b1) : v;
    endfunction

endpackage : trig_pkg
`default_nettype wire

// File: rtl/bin_window_hit.sv
`default_nettype none
// ============================================================================
// Module   : bin_window_hit
// Purpose  : Combinational per-beat test: magnitude above threshold inside the bin window.
// Revision : 1.0
// ============================================================================
module bin_window_hit
    import trig_pkg::*;
#(
    parameter int FFT_LEN = c_fft_len_default
) (
    input  logic [c_mag_w-1:0] data,
    input  logic [c_bin_w-1:0] bin_idx,
    input  logic [c_mag_w-1:0] threshold,
    input  logic [5:0]         freq_bin,
    input  logic [1:0]         bin_span,
    output logic               hit
);

    logic [c_mag_w-1:0] w_mag;
    logic [c_bin_w-1:0] w_lo;
    logic [c_bin_w-1:0] w_hi;
    logic               w_in_fft;
    logic               w_in_window;

    assign w_mag = abs_mag(data);

    // Window bounds are widened to the bin-index width so freq_bin+bin_span never wraps.
    assign w_lo = {2'b00, freq_bin};
    assign w_hi = w_lo + {6'd0, bin_span};

    assign w_in_fft    = ({1'b0, bin_idx} < (c_bin_w + 1)'(FFT_LEN));
    assign w_in_window = (bin_idx >= w_lo) && (bin_idx <= w_hi);

    assign hit = (w_mag > threshold) && w_in_window && w_in_fft;

endmodule : bin_window_hit
`default_nettype wire

// File: rtl/trigger_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : trigger_sequencer
// Purpose  : Multi-frame confirm / holdoff trigger on a windowed FFT-bin magnitude.
// Revision : 1.0
// ============================================================================
module trigger_sequencer
    import trig_pkg::*;
#(
    parameter int FFT_LEN        = c_fft_len_default,
    parameter int CONFIRM_FRAMES = 3,
    parameter int HOLDOFF_FRAMES = 8
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        arm,
    input  logic [31:0] s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    input  logic [15:0] s_tuser,
    input  logic [15:0] threshold,
    input  logic [5:0]  freq_bin,
    input  logic [1:0]  bin_span,
    output logic        s_tready,
    output logic        trigger_pulse,
    output logic        holdoff_active,
    output logic [1:0]  state_o,
    output logic [7:0]  frame_cnt
);

    localparam logic [3:0] c_confirm = 4'(CONFIRM_FRAMES);
    localparam logic [7:0] c_holdoff = 8'(HOLDOFF_FRAMES);

    state_t      r_state;
    logic        r_ready;
    logic        r_pulse;
    logic        r_holdoff;
    logic        r_hit_flag;
    logic        r_boundary;
    logic        r_synced;
    logic [3:0]  r_conf_cnt;
    logic [7:0]  r_hold_cnt;
    logic [7:0]  r_frame_cnt;

    logic        w_accept;
    logic        w_frame_end;
    logic        w_beat_hit;
    logic        w_frame_hit;
    logic [3:0]  w_conf_next;
    logic        w_unused_bits;

    assign w_unused_bits = ^{s_tdata[31:16], s_tuser[15:8]};

    bin_window_hit #(
        .FFT_LEN (FFT_LEN)
    ) u_bin_window_hit (
        .data      (s_tdata[c_mag_w-1:0]),
        .bin_idx   (s_tuser[c_bin_w-1:0]),
        .threshold (threshold),
        .freq_bin  (freq_bin),
        .bin_span  (bin_span),
        .hit       (w_beat_hit)
    );

    assign w_accept    = s_tvalid && r_ready;
    assign w_frame_end = w_accept && s_tlast;
    assign w_frame_hit = r_hit_flag || (w_accept && w_beat_hit);
    assign w_conf_next = ((r_state == ST_ARMED) ? 4'd0 : r_conf_cnt) + 4'd1;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_pulse     <= 1'b0;
            r_holdoff   <= 1'b0;
            r_hit_flag  <= 1'b0;
            r_boundary  <= 1'b0;
            r_synced    <= 1'b0;
            r_conf_cnt  <= 4'd0;
            r_hold_cnt  <= 8'd0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_ready <= 1'b1;
            r_pulse <= 1'b0;

            // Frame-boundary tracking runs even in IDLE so arming can tell whether a frame is open.
            if (w_accept) begin
                r_boundary <= s_tlast;
            end

            if (!arm) begin
                r_state     <= ST_IDLE;
                r_holdoff   <= 1'b0;
                r_hit_flag  <= 1'b0;
                r_synced    <= 1'b0;
                r_conf_cnt  <= 4'd0;
                r_hold_cnt  <= 8'd0;
                r_frame_cnt <= 8'd0;
            end else if (r_state == ST_IDLE) begin
                r_state    <= ST_ARMED;
                r_hit_flag <= 1'b0;
                r_synced   <= w_accept ? s_tlast : r_boundary;
            end else if (w_frame_end) begin
                r_hit_flag <= 1'b0;
                if (r_frame_cnt != 8'hFF) begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end

                if (!r_synced) begin
                    r_synced <= 1'b1;
                end else begin
                    case (r_state)
                        ST_ARMED, ST_CONFIRM: begin
                            if (!w_frame_hit) begin
                                r_state    <= ST_ARMED;
                                r_conf_cnt <= 4'd0;
                            end else if (w_conf_next == c_confirm) begin
                                r_pulse    <= 1'b1;
                                r_conf_cnt <= 4'd0;
                                r_hold_cnt <= 8'd0;
                                if (c_holdoff == 8'd0) begin
                                    r_state   <= ST_ARMED;
                                    r_holdoff <= 1'b0;
                                end else begin
                                    r_state   <= ST_HOLDOFF;
                                    r_holdoff <= 1'b1;
                                end
                            end else begin
                                r_state    <= ST_CONFIRM;
                                r_conf_cnt <= w_conf_next;
                            end
                        end
                        ST_HOLDOFF: begin
                            if (r_hold_cnt + 8'd1 == c_holdoff) begin
                                r_state    <= ST_ARMED;
                                r_holdoff  <= 1'b0;
                                r_hold_cnt <= 8'd0;
                            end else begin
                                r_hold_cnt <= r_hold_cnt + 8'd1;
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                        end
                    endcase
                end
            end else if (w_accept && w_beat_hit) begin
                r_hit_flag <= 1'b1;
            end
        end
    end

    assign s_tready       = r_ready;
    assign trigger_pulse  = r_pulse;
    assign holdoff_active = r_holdoff;
    assign state_o        = r_state;
    assign frame_cnt      = r_frame_cnt;

endmodule : trigger_sequencer
`default_nettype wire
